xunit_msched: RTL and testbench

XUNIT_MSCHED -- requirements
Module: xunit_msched

---
 rtl/xunit_msched_pkg.sv | 45 ++++
 rtl/xunit_msched_if.sv | 29 ++
 rtl/xunit_msched_sigma.sv | 24 ++
 rtl/xunit_msched.sv | 111 +++++++++++
 tb/tb_xunit_msched.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/xunit_msched_pkg.sv
// Shared definitions for the message-schedule expander: FSM encoding, window
// geometry, tap positions and the sigma rotate/shift amounts per word width.
package xunit_msched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_EXPAND = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

  localparam int WIN_DEPTH  = 16;
  localparam int MIN_ROUNDS = 16;
  localparam int ROUNDS_W   = 7;

  // Window entry 0 holds W[t-1], entry k holds W[t-1-k].
  localparam int TAP_S1  = 1;   // W[t-2]  -> sigma1
  localparam int TAP_T7  = 6;   // W[t-7]
  localparam int TAP_S0  = 14;  // W[t-15] -> sigma0
  localparam int TAP_T16 = 15;  // W[t-16]

  typedef struct packed {
    int s0_r1;
    int s0_r2;
    int s0_sh;
    int s1_r1;
    int s1_r2;
    int s1_sh;
  } sig_amt_t;

  // SHA-256 amounts for 32-bit words, SHA-512 amounts for 64-bit words.
  function automatic sig_amt_t sig_amt(input int data_w);
    sig_amt_t a;
    if (data_w == 64) begin
      a.s0_r1 = 1;  a.s0_r2 = 8;  a.s0_sh = 7;
      a.s1_r1 = 19; a.s1_r2 = 61; a.s1_sh = 6;
    end else begin
      a.s0_r1 = 7;  a.s0_r2 = 18; a.s0_sh = 3;
      a.s1_r1 = 17; a.s1_r2 = 19; a.s1_sh = 10;
    end
    return a;
  endfunction

endpackage

// File: rtl/xunit_msched_if.sv
// Control/data bundle of the schedule expander. With XUNIT_MSCHED_HOLD_EN
// defined the bundle also carries the hold (freeze) input.
interface xunit_msched_if
  import xunit_msched_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8
);
  logic                run;
  logic                done;
  logic [DATA_W-1:0]   in0;
  logic [DATA_W-1:0]   out0;
  logic                out_valid;
  logic [DELAY_W-1:0]  configDelay;
  logic [ROUNDS_W-1:0] configRounds;
`ifdef XUNIT_MSCHED_HOLD_EN
  logic                hold;

  modport master (output run, in0, configDelay, configRounds, hold,
                  input  done, out0, out_valid);
  modport slave  (input  run, in0, configDelay, configRounds, hold,
                  output done, out0, out_valid);
`else
  modport master (output run, in0, configDelay, configRounds,
                  input  done, out0, out_valid);
  modport slave  (input  run, in0, configDelay, configRounds,
                  output done, out0, out_valid);
`endif
endinterface

// File: rtl/xunit_msched_sigma.sv
// Combinational small-sigma functions of the SHA-2 message schedule.
module xunit_msched_sigma
  import xunit_msched_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] s0_x_i,
  input  logic [DATA_W-1:0] s1_x_i,
  output logic [DATA_W-1:0] s0_o,
  output logic [DATA_W-1:0] s1_o
);
  localparam sig_amt_t AMT = sig_amt(DATA_W);

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  // Both sigmas are pure XOR of two rotations and one logical shift.
  always_comb begin
    s0_o = rotr(s0_x_i, AMT.s0_r1) ^ rotr(s0_x_i, AMT.s0_r2) ^ (s0_x_i >> AMT.s0_sh);
    s1_o = rotr(s1_x_i, AMT.s1_r1) ^ rotr(s1_x_i, AMT.s1_r2) ^ (s1_x_i >> AMT.s1_sh);
  end

endmodule

// File: rtl/xunit_msched.sv
// SHA-256/SHA-512 message schedule expander: optional start delay, loads 16
// message words, then expands to configRounds words, one registered word per
// cycle. Optional freeze input enabled by macro XUNIT_MSCHED_HOLD_EN.
module xunit_msched
  import xunit_msched_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  xunit_msched_if.slave bus
);
  state_e              state_q, state_d;
  logic [DELAY_W-1:0]  dly_q, dly_d;
  logic [ROUNDS_W-1:0] rounds_q, rounds_d;
  logic [ROUNDS_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]   win_q [WIN_DEPTH];
  logic [DATA_W-1:0]   win_d [WIN_DEPTH];
  logic [DATA_W-1:0]   out0_q, out0_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic                adv;
  logic [DATA_W-1:0]   s0, s1, expand_w, new_w;

  xunit_msched_sigma #(.DATA_W(DATA_W)) u_sigma (
    .s0_x_i (win_q[TAP_S0]),
    .s1_x_i (win_q[TAP_S1]),
    .s0_o   (s0),
    .s1_o   (s1)
  );

  assign expand_w = s1 + win_q[TAP_T7] + s0 + win_q[TAP_T16];
  assign new_w    = (state_q == ST_LOAD) ? bus.in0 : expand_w;

  // Next-state and output logic; run overrides everything, hold freezes the rest.
  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    rounds_d    = rounds_q;
    idx_d       = idx_q;
    win_d       = win_q;
    out0_d      = out0_q;
    out_valid_d = 1'b0;
    done_d      = done_q;
    adv         = 1'b1;
`ifdef XUNIT_MSCHED_HOLD_EN
    adv         = !bus.hold;
`endif
    if (bus.run) begin
      rounds_d = (bus.configRounds < ROUNDS_W'(MIN_ROUNDS)) ? ROUNDS_W'(MIN_ROUNDS)
                                                             : bus.configRounds;
      dly_d    = bus.configDelay;
      idx_d    = '0;
      for (int i = 0; i < WIN_DEPTH; i++) win_d[i] = '0;
      state_d  = (bus.configDelay != '0) ? ST_DELAY : ST_LOAD;
    end else if (adv) begin
      case (state_q)
        ST_DELAY: begin
          dly_d = dly_q - DELAY_W'(1);
          if (dly_q <= DELAY_W'(1)) state_d = ST_LOAD;
        end
        ST_LOAD, ST_EXPAND: begin
          for (int i = WIN_DEPTH - 1; i > 0; i--) win_d[i] = win_q[i-1];
          win_d[0]    = new_w;
          out0_d      = new_w;
          out_valid_d = 1'b1;
          idx_d       = idx_q + ROUNDS_W'(1);
          if (state_q == ST_LOAD) begin
            if (idx_q == ROUNDS_W'(WIN_DEPTH - 1))
              state_d = (rounds_q == ROUNDS_W'(MIN_ROUNDS)) ? ST_FIN : ST_EXPAND;
          end else if (idx_q == rounds_q - ROUNDS_W'(1)) begin
            state_d = ST_FIN;
          end
        end
        default: ;
      endcase
    end
    // done stays low through the cycle that shows the final word.
    if (bus.run || adv)
      done_d = ((state_d == ST_IDLE) || (state_d == ST_FIN)) && !out_valid_d;
  end

  // State, counters, window and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dly_q       <= '0;
      rounds_q    <= '0;
      idx_q       <= '0;
      for (int i = 0; i < WIN_DEPTH; i++) win_q[i] <= '0;
      out0_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      rounds_q    <= rounds_d;
      idx_q       <= idx_d;
      for (int i = 0; i < WIN_DEPTH; i++) win_q[i] <= win_d[i];
      out0_q      <= out0_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.done      = done_q;
  assign bus.out0      = out0_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_xunit_msched.sv
// Scoreboard bench for xunit_msched: a 32-bit and a 64-bit instance run side by
// side; expected words (value and arrival cycle) come from a plain SHA-2
// schedule model. Define XUNIT_MSCHED_HOLD_EN to also exercise the hold input.
module tb_xunit_msched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xunit_msched_if #(.DATA_W(32), .DELAY_W(8)) bus32 ();
  xunit_msched_if #(.DATA_W(64), .DELAY_W(8)) bus64 ();

  xunit_msched #(.DATA_W(32), .DELAY_W(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  xunit_msched #(.DATA_W(64), .DELAY_W(8)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  typedef struct {
    logic [63:0] data;
    int          cyc;
    int          t;
  } exp_t;

  exp_t        q32[$];
  exp_t        q64[$];
  exp_t        e32, e64;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] got32 [128];
  logic [63:0] got64 [128];
  int          vcnt32, vcnt64;
  logic [63:0] last32, last64;
  logic [63:0] msg32 [16];
  logic [63:0] msg64 [16];
  int          base32, base64, re32, re64, lastc32, lastc64;
  int          hold_t = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    m = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    return ((x >> n) | (x << (w - n))) & m;
  endfunction

  function automatic logic [63:0] small_sigma(input int w, input bit one, input logic [63:0] x);
    if (w == 32)
      return one ? (rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10))
                 : (rotr(x, 7, 32)  ^ rotr(x, 18, 32) ^ (x >> 3));
    return one ? (rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6))
               : (rotr(x, 1, 64)  ^ rotr(x, 8, 64)  ^ (x >> 7));
  endfunction

  task automatic push_expected(input int w, input int rounds, input int base, input int ht);
    logic [63:0] W [128];
    logic [63:0] mask;
    exp_t        e;
    mask = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < rounds; t++) begin
      if (t < 16) W[t] = (w == 32) ? msg32[t] : msg64[t];
      else W[t] = (small_sigma(w, 1'b1, W[t-2]) + W[t-7] + small_sigma(w, 1'b0, W[t-15]) + W[t-16]) & mask;
      e.data = W[t];
      e.t    = t;
      e.cyc  = base + t + ((ht >= 0 && t >= ht) ? 3 : 0);
      if (w == 32) q32.push_back(e);
      else         q64.push_back(e);
    end
  endtask

  // ---------------- monitors ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) last32 = '0;
    else if (bus32.out_valid) begin
      if (q32.size() == 0) begin
        chk("w32_unexpected_valid", 64'(bus32.out_valid), 64'd0);
      end else begin
        e32 = q32.pop_front();
        chk("w32_data", {32'h0, bus32.out0}, e32.data);
        chk("w32_cycle", 64'(cyc), 64'(e32.cyc));
        got32[e32.t] = {32'h0, bus32.out0};
        vcnt32++;
      end
      last32 = {32'h0, bus32.out0};
    end else begin
      chk("w32_out0_hold", {32'h0, bus32.out0}, last32);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) last64 = '0;
    else if (bus64.out_valid) begin
      if (q64.size() == 0) begin
        chk("w64_unexpected_valid", 64'(bus64.out_valid), 64'd0);
      end else begin
        e64 = q64.pop_front();
        chk("w64_data", bus64.out0, e64.data);
        chk("w64_cycle", 64'(cyc), 64'(e64.cyc));
        got64[e64.t] = bus64.out0;
        vcnt64++;
      end
      last64 = bus64.out0;
    end else begin
      chk("w64_out0_hold", bus64.out0, last64);
    end
  end

  // ---------------- stimulus ----------------
  // Drive inputs for the coming edge: message words exactly in the load window.
  task automatic drive();
    int k32, k64;
    k32 = cyc + 1 - base32;
    k64 = cyc + 1 - base64;
    bus32.in0 = (k32 >= 0 && k32 < 16) ? msg32[k32][31:0] : $urandom();
    bus64.in0 = (k64 >= 0 && k64 < 16) ? msg64[k64] : {$urandom(), $urandom()};
`ifdef XUNIT_MSCHED_HOLD_EN
    bus32.hold = (hold_t >= 0 && k32 >= hold_t && k32 < hold_t + 3);
    bus64.hold = (hold_t >= 0 && k64 >= hold_t && k64 < hold_t + 3);
`endif
  endtask

  task automatic step();
    drive();
    @(negedge clk);
  endtask

  task automatic issue_run(input int d32, input int r32, input int d64, input int r64,
                           input bit abc, input int ht);
    bus32.configDelay  = 8'(d32);
    bus32.configRounds = 7'(r32);
    bus64.configDelay  = 8'(d64);
    bus64.configRounds = 7'(r64);
    bus32.run = 1'b1;
    bus64.run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      msg32[i] = abc ? 64'h0 : {32'h0, $urandom()};
      msg64[i] = abc ? 64'h0 : {$urandom(), $urandom()};
    end
    if (abc) begin
      msg32[0]  = 64'h0000_0000_6162_6380;
      msg32[15] = 64'h18;
      msg64[0]  = 64'h6162_6380_0000_0000;
      msg64[15] = 64'h18;
    end
    #1;
    while (q32.size() > 0 && q32[q32.size()-1].cyc > cyc) q32.delete(q32.size()-1);
    while (q64.size() > 0 && q64[q64.size()-1].cyc > cyc) q64.delete(q64.size()-1);
    hold_t  = ht;
    re32    = (r32 < 16) ? 16 : r32;
    re64    = (r64 < 16) ? 16 : r64;
    base32  = cyc + 2 + d32;
    base64  = cyc + 2 + d64;
    lastc32 = base32 + re32 - 1 + ((ht >= 0) ? 3 : 0);
    lastc64 = base64 + re64 - 1 + ((ht >= 0) ? 3 : 0);
    vcnt32  = 0;
    vcnt64  = 0;
    push_expected(32, re32, base32, ht);
    push_expected(64, re64, base64, ht);
    bus32.in0 = $urandom();
    bus64.in0 = {$urandom(), $urandom()};
    @(negedge clk);
    bus32.run = 1'b0;
    bus64.run = 1'b0;
    // Config changes after the run cycle must be ignored.
    bus32.configDelay  = 8'($urandom_range(1, 255));
    bus32.configRounds = 7'($urandom_range(0, 127));
    bus64.configDelay  = 8'($urandom_range(1, 255));
    bus64.configRounds = 7'($urandom_range(0, 127));
    chk("done32_after_run", 64'(bus32.done), 64'd0);
    chk("done64_after_run", 64'(bus64.done), 64'd0);
  endtask

  task automatic finish_run();
    int endc;
    endc = ((lastc32 > lastc64) ? lastc32 : lastc64) + 2;
    while (cyc < endc) begin
      if (cyc == lastc32) chk("done32_at_last_word", 64'(bus32.done), 64'd0);
      if (cyc == lastc64) chk("done64_at_last_word", 64'(bus64.done), 64'd0);
      if (cyc == lastc32 + 1) begin
        chk("done32_rise", 64'(bus32.done), 64'd1);
        chk("count32", 64'(vcnt32), 64'(re32));
      end
      if (cyc == lastc64 + 1) begin
        chk("done64_rise", 64'(bus64.done), 64'd1);
        chk("count64", 64'(vcnt64), 64'(re64));
      end
      step();
    end
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q64_drained", 64'(q64.size()), 64'd0);
  endtask

  initial begin
    bus32.run = 1'b0; bus64.run = 1'b0;
    bus32.in0 = '0;   bus64.in0 = '0;
    bus32.configDelay = '0; bus32.configRounds = '0;
    bus64.configDelay = '0; bus64.configRounds = '0;
`ifdef XUNIT_MSCHED_HOLD_EN
    bus32.hold = 1'b0; bus64.hold = 1'b0;
`endif
    base32 = -100; base64 = -100;
    repeat (3) @(negedge clk);
    chk("rst_done32", 64'(bus32.done), 64'd1);
    chk("rst_valid32", 64'(bus32.out_valid), 64'd0);
    chk("rst_out32", {32'h0, bus32.out0}, 64'd0);
    chk("rst_done64", 64'(bus64.done), 64'd1);
    chk("rst_out64", bus64.out0, 64'd0);
    rst_n = 1'b1;
    repeat (4) step();
    chk("idle_done32", 64'(bus32.done), 64'd1);

    // "abc" padded blocks, full SHA-256 / SHA-512 schedules.
    issue_run(0, 64, 0, 80, 1'b1, -1);
    finish_run();
    chk("abc32_W16", got32[16], 64'h6162_6380);
    chk("abc32_W17", got32[17], 64'h000F_0000);
    chk("abc64_W16", got64[16], 64'h6162_6380_0000_0000);

    // Start delay, then clamp of short round counts.
    issue_run(5, 20, 5, 17, 1'b0, -1);
    finish_run();
    issue_run(0, 3, 2, 0, 1'b0, -1);
    finish_run();

    // Random configurations.
    for (int n = 0; n < 6; n++) begin
      issue_run($urandom_range(0, 7), $urandom_range(0, 127),
                $urandom_range(0, 7), $urandom_range(0, 127), 1'b0, -1);
      finish_run();
    end

    // Restart mid-EXPAND.
    issue_run(0, 64, 0, 80, 1'b0, -1);
    while (cyc < base32 + 30) step();
    issue_run($urandom_range(0, 4), $urandom_range(16, 60), $urandom_range(0, 4), $urandom_range(16, 60), 1'b0, -1);
    finish_run();

    // Reset mid-LOAD: immediate idle, no resumption without run.
    issue_run(0, 40, 1, 40, 1'b0, -1);
    while (cyc < base32 + 8) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid32", 64'(bus32.out_valid), 64'd0);
    chk("midrst_out32", {32'h0, bus32.out0}, 64'd0);
    chk("midrst_done32", 64'(bus32.done), 64'd1);
    chk("midrst_valid64", 64'(bus64.out_valid), 64'd0);
    chk("midrst_out64", bus64.out0, 64'd0);
    chk("midrst_done64", 64'(bus64.done), 64'd1);
    q32.delete();
    q64.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) step();
    chk("postrst_done32", 64'(bus32.done), 64'd1);
    chk("postrst_done64", 64'(bus64.done), 64'd1);
    issue_run(1, 30, 0, 30, 1'b0, -1);
    finish_run();

`ifdef XUNIT_MSCHED_HOLD_EN
    // Hold for three cycles in the middle of expansion.
    issue_run(0, 40, 0, 40, 1'b0, 20);
    finish_run();
    hold_t = -1;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
